// File: rtl/sram_arbiter_if.sv
// Bus bundle between two requesters, the sram_arbiter and the shared sram_controller.
// master = requesters + controller side, slave = arbiter side.
interface sram_arbiter_if #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 8
);
  logic                 p0_req;
  logic                 p0_ready;
  logic                 p0_write_enable;
  logic [ADDR_BITS-1:0] p0_addr;
  logic [DATA_BITS-1:0] p0_write_data;
  logic                 p0_write_done;
  logic [DATA_BITS-1:0] p0_read_data;
  logic                 p0_read_data_valid;

  logic                 p1_req;
  logic                 p1_ready;
  logic                 p1_write_enable;
  logic [ADDR_BITS-1:0] p1_addr;
  logic [DATA_BITS-1:0] p1_write_data;
  logic                 p1_write_done;
  logic [DATA_BITS-1:0] p1_read_data;
  logic                 p1_read_data_valid;

  logic                 ctrl_req;
  logic                 ctrl_ready;
  logic                 ctrl_write_enable;
  logic [ADDR_BITS-1:0] ctrl_addr;
  logic [DATA_BITS-1:0] ctrl_write_data;
  logic                 ctrl_write_done;
  logic [DATA_BITS-1:0] ctrl_read_data;
  logic                 ctrl_read_data_valid;

  logic                 err;

  modport master (
    output p0_req, p0_write_enable, p0_addr, p0_write_data,
    input  p0_ready, p0_write_done, p0_read_data, p0_read_data_valid,
    output p1_req, p1_write_enable, p1_addr, p1_write_data,
    input  p1_ready, p1_write_done, p1_read_data, p1_read_data_valid,
    input  ctrl_req, ctrl_write_enable, ctrl_addr, ctrl_write_data,
    output ctrl_ready, ctrl_write_done, ctrl_read_data, ctrl_read_data_valid,
    input  err
  );

  modport slave (
    input  p0_req, p0_write_enable, p0_addr, p0_write_data,
    output p0_ready, p0_write_done, p0_read_data, p0_read_data_valid,
    input  p1_req, p1_write_enable, p1_addr, p1_write_data,
    output p1_ready, p1_write_done, p1_read_data, p1_read_data_valid,
    output ctrl_req, ctrl_write_enable, ctrl_addr, ctrl_write_data,
    input  ctrl_ready, ctrl_write_done, ctrl_read_data, ctrl_read_data_valid,
    output err
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of one sram_controller; an in-order tag FIFO routes completions back.
// Define SRAM_ARBITER_FIXED_PRIORITY_EN to make port 0 always win contention (port 1 may starve).
module sram_arbiter #(
  parameter int ADDR_BITS       = 10,
  parameter int DATA_BITS       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic                 tag_port [MAX_OUTSTANDING];
  logic                 tag_we   [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 err_q;
  logic                 p0_rdv_q;
  logic                 p1_rdv_q;
  logic                 p0_wd_q;
  logic                 p1_wd_q;
  logic [DATA_BITS-1:0] p0_rd_q;
  logic [DATA_BITS-1:0] p1_rd_q;

  logic                 grant0;
  logic                 grant1;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 any_cpl;
  logic                 pop;
  logic                 cpl_ok;
  logic                 head_port;
  logic                 head_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;
  logic                 sel_we;

`ifdef SRAM_ARBITER_FIXED_PRIORITY_EN
  assign grant0 = bus.p0_req;
  assign grant1 = bus.p1_req && !bus.p0_req;
`else
  logic last_grant;

  // On contention the port that did not win last time gets the slot.
  assign grant0 = bus.p0_req && (!bus.p1_req || last_grant);
  assign grant1 = bus.p1_req && (!bus.p0_req || !last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant <= 1'b1;
    else if (accept) last_grant <= grant1;
  end
`endif

  assign full   = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty  = (count == '0);
  assign accept = bus.ctrl_req && bus.ctrl_ready;

  assign sel_addr  = grant1 ? bus.p1_addr         : bus.p0_addr;
  assign sel_wdata = grant1 ? bus.p1_write_data   : bus.p0_write_data;
  assign sel_we    = grant1 ? bus.p1_write_enable : bus.p0_write_enable;

  assign bus.ctrl_req          = (bus.p0_req || bus.p1_req) && !full;
  assign bus.ctrl_addr         = sel_addr;
  assign bus.ctrl_write_data   = sel_wdata;
  assign bus.ctrl_write_enable = sel_we;
  assign bus.p0_ready          = grant0 && bus.ctrl_ready && !full;
  assign bus.p1_ready          = grant1 && bus.ctrl_ready && !full;

  assign head_port = tag_port[rd_ptr];
  assign head_we   = tag_we[rd_ptr];
  assign any_cpl   = bus.ctrl_read_data_valid || bus.ctrl_write_done;
  assign pop       = any_cpl && !empty;
  // A completion is only routed when it is unambiguous and matches the head's type.
  assign cpl_ok    = pop && (bus.ctrl_read_data_valid ^ bus.ctrl_write_done) &&
                     (head_we == bus.ctrl_write_done);

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_port[wr_ptr] <= grant1;
      tag_we[wr_ptr]   <= sel_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
      p0_rdv_q <= 1'b0;
      p1_rdv_q <= 1'b0;
      p0_wd_q  <= 1'b0;
      p1_wd_q  <= 1'b0;
      p0_rd_q  <= '0;
      p1_rd_q  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (any_cpl && !cpl_ok) err_q <= 1'b1;
      p0_rdv_q <= cpl_ok && bus.ctrl_read_data_valid && !head_port;
      p1_rdv_q <= cpl_ok && bus.ctrl_read_data_valid &&  head_port;
      p0_wd_q  <= cpl_ok && bus.ctrl_write_done && !head_port;
      p1_wd_q  <= cpl_ok && bus.ctrl_write_done &&  head_port;
      if (cpl_ok && bus.ctrl_read_data_valid && !head_port) p0_rd_q <= bus.ctrl_read_data;
      if (cpl_ok && bus.ctrl_read_data_valid &&  head_port) p1_rd_q <= bus.ctrl_read_data;
    end
  end

  assign bus.p0_read_data_valid = p0_rdv_q;
  assign bus.p1_read_data_valid = p1_rdv_q;
  assign bus.p0_write_done      = p0_wd_q;
  assign bus.p1_write_done      = p1_wd_q;
  assign bus.p0_read_data       = p0_rd_q;
  assign bus.p1_read_data       = p1_rd_q;
  assign bus.err                = err_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an in-order controller model and a completion event log.
module tb_sram_arbiter;
`ifdef SRAM_ARBITER_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  sram_arbiter_if #(.ADDR_BITS(10), .DATA_BITS(8)) bus ();

  sram_arbiter #(.ADDR_BITS(10), .DATA_BITS(8), .MAX_OUTSTANDING(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: accepts are sampled at the negedge before the edge that takes them,
  // completions are issued in order one per cycle unless stalled.
  logic        stall;
  logic        inj_rdv;
  logic        pend;
  logic        pend_port;
  logic        pend_we;
  logic [9:0]  pend_addr;
  logic [7:0]  pend_data;
  logic [7:0]  mem [1024];
  logic [18:0] q [$];
  logic [18:0] e;
  bit          glog [$];
  logic [9:0]  ev [$];

  always @(negedge clk) begin
    pend      = bus.ctrl_req && bus.ctrl_ready;
    pend_port = bus.p1_ready;
    pend_we   = bus.ctrl_write_enable;
    pend_addr = bus.ctrl_addr;
    pend_data = bus.ctrl_write_data;
    if (bus.p0_read_data_valid) ev.push_back({2'b00, bus.p0_read_data});
    if (bus.p1_read_data_valid) ev.push_back({2'b01, bus.p1_read_data});
    if (bus.p0_write_done)      ev.push_back(10'h200);
    if (bus.p1_write_done)      ev.push_back(10'h300);
  end

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
    end else if (pend) begin
      q.push_back({pend_we, pend_addr, pend_data});
      glog.push_back(pend_port);
      if (pend_we) mem[pend_addr] = pend_data;
    end
    #1;
    bus.ctrl_read_data_valid = inj_rdv;
    bus.ctrl_write_done      = 1'b0;
    if (!stall && !reset && q.size() > 0) begin
      e = q.pop_front();
      if (e[18]) bus.ctrl_write_done = 1'b1;
      else begin
        bus.ctrl_read_data_valid = 1'b1;
        bus.ctrl_read_data       = mem[e[17:8]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [9:0] a, input logic [7:0] d);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_write_enable = we; bus.p0_addr = a; bus.p0_write_data = d;
    end else begin
      bus.p1_req = req; bus.p1_write_enable = we; bus.p1_addr = a; bus.p1_write_data = d;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", bus.err); end
    total++; if (bus.p0_read_data_valid !== 1'b0 || bus.p1_read_data_valid !== 1'b0) begin bad++; $display("FAIL rst_rdv got=%b%b want=00", bus.p0_read_data_valid, bus.p1_read_data_valid); end
    total++; if (bus.p0_write_done !== 1'b0 || bus.p1_write_done !== 1'b0) begin bad++; $display("FAIL rst_wd got=%b%b want=00", bus.p0_write_done, bus.p1_write_done); end
    total++; if (bus.p0_read_data !== 8'h00 || bus.p1_read_data !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h/%h want=00/00", bus.p0_read_data, bus.p1_read_data); end
    total++; if (bus.ctrl_req !== 1'b0) begin bad++; $display("FAIL rst_ctrl_req got=%b want=0", bus.ctrl_req); end
    bus.p0_req = 1'b1; bus.p1_req = 1'b1;
    #1;
    total++; if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b0) begin bad++; $display("FAIL rst_first_grant got=%b%b want=10", bus.p0_ready, bus.p1_ready); end
    total++; if (bus.ctrl_req !== 1'b1) begin bad++; $display("FAIL rst_ctrl_req_contend got=%b want=1", bus.ctrl_req); end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic issue_one_each(input string tag);
    logic r0, r1;
    for (int c = 0; c < 10 && (bus.p0_req || bus.p1_req); c++) begin
      #1;
      r0 = bus.p0_ready; r1 = bus.p1_ready;
      tick();
      if (r0) bus.p0_req = 1'b0;
      if (r1) bus.p1_req = 1'b0;
    end
    total++; if (bus.p0_req || bus.p1_req) begin bad++; $display("FAIL %s_timeout got=pending want=both_accepted", tag); end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_write_alternate();
    logic [9:0] want [2];
    want[0] = 10'h200; want[1] = 10'h300;
    glog.delete(); ev.delete();
    set_port(0, 1'b1, 1'b1, 10'h101, 8'h51);
    set_port(1, 1'b1, 1'b1, 10'h102, 8'h52);
    issue_one_each("wr");
    total++; if (glog.size() != 2) begin bad++; $display("FAIL wr_grant_count got=%0d want=2", glog.size()); end
    for (int i = 0; i < 2; i++) begin
      total++; if ((i < glog.size() ? 32'(glog[i]) : 32'd9) !== 32'(i)) begin bad++; $display("FAIL wr_grant[%0d] got=%0d want=%0d", i, (i < glog.size() ? 32'(glog[i]) : 32'd9), i); end
    end
    total++; if (ev.size() != 2) begin bad++; $display("FAIL wr_ev_count got=%0d want=2", ev.size()); end
    for (int i = 0; i < 2; i++) begin
      total++; if ((i < ev.size() ? ev[i] : 10'h3ff) !== want[i]) begin bad++; $display("FAIL wr_ev[%0d] got=%h want=%h", i, (i < ev.size() ? ev[i] : 10'h3ff), want[i]); end
    end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", bus.err); end
  endtask

  task automatic test_read_back_to_back();
    logic [9:0] want [2];
    want[0] = 10'h051; want[1] = 10'h152;
    ev.delete();
    set_port(0, 1'b1, 1'b0, 10'h101, 8'h00);
    set_port(1, 1'b1, 1'b0, 10'h102, 8'h00);
    issue_one_each("rd");
    total++; if (ev.size() != 2) begin bad++; $display("FAIL rd_ev_count got=%0d want=2", ev.size()); end
    for (int i = 0; i < 2; i++) begin
      total++; if ((i < ev.size() ? ev[i] : 10'h3ff) !== want[i]) begin bad++; $display("FAIL rd_ev[%0d] got=%h want=%h", i, (i < ev.size() ? ev[i] : 10'h3ff), want[i]); end
    end
    total++; if (bus.p0_read_data !== 8'h51 || bus.p1_read_data !== 8'h52) begin bad++; $display("FAIL rd_hold got=%h/%h want=51/52", bus.p0_read_data, bus.p1_read_data); end
  endtask

  task automatic test_full();
    logic [9:0] want;
    int         wp;
    glog.delete(); ev.delete();
    stall = 1'b1;
    set_port(0, 1'b1, 1'b0, 10'h101, 8'h00);
    set_port(1, 1'b1, 1'b0, 10'h102, 8'h00);
    repeat (4) tick();
    #1;
    total++; if (bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0 || bus.ctrl_req !== 1'b0) begin bad++; $display("FAIL full_block got=%b%b%b want=000", bus.p0_ready, bus.p1_ready, bus.ctrl_req); end
    tick();
    total++; if (bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0) begin bad++; $display("FAIL full_hold got=%b%b want=00", bus.p0_ready, bus.p1_ready); end
    stall = 1'b0;
    tick();
    total++; if (bus.p0_ready !== 1'b0 || bus.p1_ready !== 1'b0) begin bad++; $display("FAIL full_prepop got=%b%b want=00", bus.p0_ready, bus.p1_ready); end
    tick();
    total++; if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b0) begin bad++; $display("FAIL full_ready_back got=%b%b want=10", bus.p0_ready, bus.p1_ready); end
    total++; if (bus.p0_read_data_valid !== 1'b1 || bus.p0_read_data !== 8'h51) begin bad++; $display("FAIL full_first_pop got=%b/%h want=1/51", bus.p0_read_data_valid, bus.p0_read_data); end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    repeat (8) tick();
    total++; if (glog.size() != 4) begin bad++; $display("FAIL full_grant_count got=%0d want=4", glog.size()); end
    total++; if (ev.size() != 4) begin bad++; $display("FAIL full_ev_count got=%0d want=4", ev.size()); end
    for (int i = 0; i < 4; i++) begin
      wp   = FIXED ? 0 : i % 2;
      want = (wp == 0) ? 10'h051 : 10'h152;
      total++; if ((i < glog.size() ? 32'(glog[i]) : 32'd9) !== 32'(wp)) begin bad++; $display("FAIL full_grant[%0d] got=%0d want=%0d", i, (i < glog.size() ? 32'(glog[i]) : 32'd9), wp); end
      total++; if ((i < ev.size() ? ev[i] : 10'h3ff) !== want) begin bad++; $display("FAIL full_ev[%0d] got=%h want=%h", i, (i < ev.size() ? ev[i] : 10'h3ff), want); end
    end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL full_err got=%b want=0", bus.err); end
  endtask

  task automatic test_err_inject();
    ev.delete();
    inj_rdv = 1'b1;
    tick();
    inj_rdv = 1'b0;
    tick();
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", bus.err); end
    total++; if (bus.p0_read_data_valid !== 1'b0 || bus.p1_read_data_valid !== 1'b0) begin bad++; $display("FAIL err_no_pulse got=%b%b want=00", bus.p0_read_data_valid, bus.p1_read_data_valid); end
    repeat (3) tick();
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err); end
    total++; if (ev.size() != 0) begin bad++; $display("FAIL err_events got=%0d want=0", ev.size()); end
    reset = 1'b1;
    #1;
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bus.err); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    stall = 1'b1;
    set_port(0, 1'b1, 1'b0, 10'h101, 8'h00);
    repeat (4) tick();
    bus.p0_req = 1'b0;
    stall = 1'b0;
    total++; if (dut.count !== 3'd4) begin bad++; $display("FAIL mid_count_full got=%0d want=4", dut.count); end
    repeat (2) tick();
    total++; if (bus.p0_read_data_valid !== 1'b1) begin bad++; $display("FAIL mid_pulse got=%b want=1", bus.p0_read_data_valid); end
    reset = 1'b1;
    #1;
    total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL mid_count_reset got=%0d want=0", dut.count); end
    total++; if (bus.p0_read_data_valid !== 1'b0 || bus.p0_read_data !== 8'h00) begin bad++; $display("FAIL mid_pulse_reset got=%b/%h want=0/00", bus.p0_read_data_valid, bus.p0_read_data); end
    tick();
    reset = 1'b0;
    glog.delete(); ev.delete();
    bus.p0_req = 1'b1; bus.p1_req = 1'b1;
    #1;
    total++; if (bus.p0_ready !== 1'b1 || bus.p1_ready !== 1'b0) begin bad++; $display("FAIL mid_first_grant got=%b%b want=10", bus.p0_ready, bus.p1_ready); end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    repeat (4) tick();
    total++; if (ev.size() != 0 || bus.err !== 1'b0) begin bad++; $display("FAIL mid_stale got=%0d/%b want=0/0", ev.size(), bus.err); end
  endtask

  task automatic test_priority();
    logic w0, w1;
    glog.delete();
    set_port(0, 1'b1, 1'b0, 10'h101, 8'h00);
    set_port(1, 1'b1, 1'b0, 10'h102, 8'h00);
    for (int i = 0; i < 6; i++) begin
      w0 = FIXED ? 1'b1 : (i % 2 == 0);
      w1 = !w0;
      #1;
      total++; if (bus.p0_ready !== w0 || bus.p1_ready !== w1) begin bad++; $display("FAIL prio_ready[%0d] got=%b%b want=%b%b", i, bus.p0_ready, bus.p1_ready, w0, w1); end
      tick();
    end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    repeat (6) tick();
    total++; if (glog.size() != 6) begin bad++; $display("FAIL prio_grant_count got=%0d want=6", glog.size()); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL prio_err got=%b want=0", bus.err); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    stall = 1'b0; inj_rdv = 1'b0;
    bus.ctrl_ready = 1'b1;
    set_port(0, 1'b0, 1'b0, 10'h000, 8'h00);
    set_port(1, 1'b0, 1'b0, 10'h000, 8'h00);
    test_reset();
    test_write_alternate();
    test_read_back_to_back();
    test_full();
    test_err_inject();
    test_reset_midflight();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
